// File: rtl/fir_out_buffer.sv
// Elastic show-ahead FIFO between the FIR output and a consumer that can stall.
// Samples arriving while full are dropped and counted (sticky OVF, saturating DROP_CNT).
module fir_out_buffer #(
    parameter int NB    = 9,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    input  logic [NB-1:0]            DIN,
    input  logic                     VIN,
    input  logic                     RDY,
    input  logic                     CLR_OVF,
    output logic [NB-1:0]            DOUT,
    output logic                     VOUT,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVF,
    output logic [CNT_W-1:0]         DROP_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NB-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic empty, full, pop, push, drop;

    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == FULL_LVL);
        pop   = !empty && RDY;
        // A pop in the same cycle frees a slot, so a full buffer still accepts.
        push  = VIN && (!full || pop);
        drop  = VIN && full && !pop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

        // A drop coinciding with a clear restarts the count at one.
        if (drop) begin
            ovf_d = 1'b1;
            if (CLR_OVF)                  drop_cnt_d = CNT_ONE;
            else if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_ONE;
        end else if (CLR_OVF) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_n && push) mem_q[wr_ptr_q] <= DIN;
    end

    assign VOUT     = !empty;
    assign DOUT     = empty ? '0 : mem_q[rd_ptr_q];
    assign LEVEL    = level_q;
    assign OVF      = ovf_q;
    assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed + randomized bench for fir_out_buffer against a queue-based reference model.
module tb_fir_out_buffer;

    localparam int NB    = 9;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic [NB-1:0] DIN = '0;
    logic          VIN = 1'b0;
    logic          RDY = 1'b0;
    logic          CLR_OVF = 1'b0;
    logic [NB-1:0] DOUT;
    logic          VOUT;
    logic [3:0]    LEVEL;
    logic          OVF;
    logic [CNT_W-1:0] DROP_CNT;

    fir_out_buffer #(.NB(NB), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_n(RST_n), .DIN(DIN), .VIN(VIN), .RDY(RDY), .CLR_OVF(CLR_OVF),
        .DOUT(DOUT), .VOUT(VOUT), .LEVEL(LEVEL), .OVF(OVF), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the buffer contents as a queue, plus drop bookkeeping.
    logic [NB-1:0] mq[$];
    bit m_ovf = 0;
    int m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, vin, input logic [NB-1:0] din, input logic rdy, clr);
        bit dropped;
        if (!rst) begin
            mq.delete();
            m_ovf = 0;
            m_cnt = 0;
            return;
        end
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        dropped = 0;
        if (vin) begin
            if (mq.size() < DEPTH) mq.push_back(din);
            else dropped = 1;
        end
        if (dropped) begin
            m_ovf = 1;
            m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (clr) begin
            m_ovf = 0;
            m_cnt = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [NB-1:0] exp_d;
        exp_d = (mq.size() > 0) ? mq[0] : '0;
        chk({tag, ".dout"},  32'(DOUT),     32'(exp_d));
        chk({tag, ".vout"},  32'(VOUT),     32'(mq.size() > 0));
        chk({tag, ".level"}, 32'(LEVEL),    32'(mq.size()));
        chk({tag, ".ovf"},   32'(OVF),      32'(m_ovf));
        chk({tag, ".cnt"},   32'(DROP_CNT), 32'(m_cnt));
    endtask

    task automatic step(input string tag, input logic rst, vin, input logic [NB-1:0] din,
                        input logic rdy, clr);
        RST_n = rst; VIN = vin; DIN = din; RDY = rdy; CLR_OVF = clr;
        @(posedge CLK);
        model_edge(rst, vin, din, rdy, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        int vcount;
        int maxlvl;
        int pr;
        logic [NB-1:0] v;

        // Reset and idle
        step("rst", 0, 0, '0, 0, 0);
        step("rst", 0, 0, '0, 0, 0);
        chk("rst.dout", 32'(DOUT), 0);
        chk("rst.level", 32'(LEVEL), 0);
        for (int i = 0; i < 3; i++) begin
            step("idle", 1, 0, '0, 0, 0);
            chk("idle.level", 32'(LEVEL), 0);
        end

        // Streaming -10..+9 with RDY held high
        vcount = 0; maxlvl = 0;
        for (int k = -10; k < 10; k++) begin
            step("stream", 1, 1, NB'(k), 1, 0);
            v = NB'(k);
            chk("stream.seq", 32'(DOUT), 32'(v));
            if (VOUT) vcount++;
            if (int'(LEVEL) > maxlvl) maxlvl = int'(LEVEL);
        end
        for (int i = 0; i < 3; i++) begin
            step("stream.tail", 1, 0, '0, 1, 0);
            if (VOUT) vcount++;
        end
        chk("stream.vcount", 32'(vcount), 20);
        chk("stream.lvl_le1", 32'(maxlvl <= 1), 1);
        chk("stream.ovf", 32'(OVF), 0);

        // Fill and drop
        for (int k = 1; k <= 10; k++) step("fill", 1, 1, NB'(k), 0, 0);
        chk("fill.level", 32'(LEVEL), 8);
        chk("fill.dout", 32'(DOUT), 1);
        chk("fill.ovf", 32'(OVF), 1);
        chk("fill.cnt", 32'(DROP_CNT), 2);
        for (int i = 1; i <= 8; i++) begin
            chk("drain.order", 32'(DOUT), 32'(i));
            step("drain", 1, 0, '0, 1, 0);
        end
        chk("drain.level", 32'(LEVEL), 0);
        chk("drain.vout", 32'(VOUT), 0);

        // Full with simultaneous push and pop
        step("clr", 1, 0, '0, 0, 1);
        for (int k = 1; k <= 8; k++) step("fill2", 1, 1, NB'(k), 0, 0);
        step("pushpop", 1, 1, 9'h100, 1, 0);
        chk("pushpop.level", 32'(LEVEL), 8);
        chk("pushpop.cnt", 32'(DROP_CNT), 0);
        chk("pushpop.ovf", 32'(OVF), 0);
        for (int i = 2; i <= 9; i++) begin
            v = (i == 9) ? 9'h100 : NB'(i);
            chk("pushpop.order", 32'(DOUT), 32'(v));
            step("drain2", 1, 0, '0, 1, 0);
        end

        // Saturation and clear
        for (int k = 1; k <= 8; k++) step("fill3", 1, 1, NB'(k + 20), 0, 0);
        for (int i = 0; i < 300; i++) step("sat", 1, 1, NB'(i), 0, 0);
        chk("sat.cnt", 32'(DROP_CNT), 255);
        chk("sat.ovf", 32'(OVF), 1);
        step("clr_alone", 1, 0, '0, 0, 1);
        chk("clr_alone.cnt", 32'(DROP_CNT), 0);
        chk("clr_alone.ovf", 32'(OVF), 0);
        step("drop", 1, 1, 9'h033, 0, 0);
        step("drop", 1, 1, 9'h034, 0, 0);
        step("clr_drop", 1, 1, 9'h035, 0, 1);
        chk("clr_drop.cnt", 32'(DROP_CNT), 1);
        chk("clr_drop.ovf", 32'(OVF), 1);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, '0, 1, 0);
        chk("pre_rst.level", 32'(LEVEL), 5);
        chk("pre_rst.ovf", 32'(OVF), 1);
        step("midrst", 0, 1, 9'h007, 1, 0);
        chk("midrst.level", 32'(LEVEL), 0);
        chk("midrst.vout", 32'(VOUT), 0);
        chk("midrst.ovf", 32'(OVF), 0);
        chk("midrst.cnt", 32'(DROP_CNT), 0);
        step("push42", 1, 1, NB'(42), 0, 0);
        chk("push42.dout", 32'(DOUT), 42);
        chk("push42.level", 32'(LEVEL), 1);
        step("pop42", 1, 0, '0, 1, 0);
        chk("pop42.vout", 32'(VOUT), 0);
        chk("pop42.dout", 32'(DOUT), 0);

        // Randomized traffic; ready probability changes every 50 cycles
        pr = 50;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) pr = $urandom_range(10, 95);
            step("rand",
                 ($urandom_range(0, 149) != 0),
                 ($urandom_range(0, 99) < 70),
                 NB'($urandom),
                 ($urandom_range(0, 99) < pr),
                 ($urandom_range(0, 29) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
